// File: rtl/sa_data_skew_pkg.sv
// Shared parameters, FSM state encoding and sizing helper for the systolic-array
// data-setup stage.
package sa_data_skew_pkg;

  localparam int SA_SIZE_DEF = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sa_state_e;

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_data_skew_if.sv
// Controller / feature-buffer / array-edge signal bundle of the data-setup stage.
// The slave side is the skew stage itself; the master side is its environment.
interface sa_data_skew_if #(
  parameter int SA_SIZE = 16,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10
);
  logic                        data_enable_i;
  logic [ADDR_W-1:0]           num_vec_i;
  logic                        rd_en_o;
  logic [ADDR_W-1:0]           rd_addr_o;
  logic [SA_SIZE*DATA_W-1:0]   rd_data_i;
  logic [SA_SIZE*DATA_W-1:0]   a_data_o;
  logic [SA_SIZE-1:0]          a_valid_o;
  logic                        data_last_o;
  logic                        conv_done_o;

  modport slave (
    input  data_enable_i, num_vec_i, rd_data_i,
    output rd_en_o, rd_addr_o, a_data_o, a_valid_o, data_last_o, conv_done_o
  );

  modport master (
    output data_enable_i, num_vec_i, rd_data_i,
    input  rd_en_o, rd_addr_o, a_data_o, a_valid_o, data_last_o, conv_done_o
  );
endinterface

// File: rtl/sa_data_skew_line.sv
// One lane of the west-edge skew: DEPTH-stage {valid,data} shift register that
// shifts every cycle; data is forced to zero whenever valid is low.
module sa_data_skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0]             valid_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_d;

  // Next-stage values: capture into stage 0, shift the rest by one.
  always_comb begin
    valid_d = '0;
    data_d  = '0;
    valid_d[0] = valid_i;
    if (valid_i) begin
      data_d[0] = data_i;
    end else begin
      data_d[0] = '0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sa_data_skew.sv
// Data-setup stage: reads one activation vector per enabled cycle and skews lane k
// by k cycles into the systolic array, reporting last-read and drain-complete pulses.
module sa_data_skew
  import sa_data_skew_pkg::*;
#(
  parameter int SA_SIZE = SA_SIZE_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  sa_data_skew_if.slave   bus
);

  localparam int CNT_W = cnt_width(SA_SIZE + 1);

  sa_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  num_vec_q, num_vec_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic               rd_vld_q, rd_vld_d;
  logic               conv_done_q, conv_done_d;
  logic               rd_en;
  logic               last_rd;

  // Next-state, read strobe and last-read decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    num_vec_d = num_vec_q;
    drain_d   = drain_q;
    rd_en     = 1'b0;
    last_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d  = '0;
        drain_d = '0;
        if (bus.data_enable_i) begin
          if (bus.num_vec_i != '0) begin
            rd_en     = 1'b1;
            num_vec_d = bus.num_vec_i;
            if (bus.num_vec_i == ADDR_W'(1)) begin
              last_rd = 1'b1;
              state_d = S_DRAIN;
            end else begin
              addr_d  = ADDR_W'(1);
              state_d = S_FEED;
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        if (bus.data_enable_i) begin
          rd_en = 1'b1;
          if (addr_q == (num_vec_q - ADDR_W'(1))) begin
            last_rd = 1'b1;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = S_FEED;
        end
      end
      // Hold here until the last element has cleared lane SA_SIZE-1.
      S_DRAIN: begin
        if (drain_q == CNT_W'(SA_SIZE)) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        addr_d  = '0;
        drain_d = '0;
        state_d = S_IDLE;
      end
    endcase
    rd_vld_d    = rd_en;
    conv_done_d = (state_d == S_DONE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      num_vec_q   <= '0;
      drain_q     <= '0;
      rd_vld_q    <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_vec_q   <= num_vec_d;
      drain_q     <= drain_d;
      rd_vld_q    <= rd_vld_d;
      conv_done_q <= conv_done_d;
    end
  end

  assign bus.rd_en_o     = rd_en;
  assign bus.rd_addr_o   = addr_q;
  assign bus.data_last_o = last_rd;
  assign bus.conv_done_o = conv_done_q;

  // Lane k: capture register plus k delay stages, fed by the returned read word.
  for (genvar k = 0; k < SA_SIZE; k++) begin : g_lane
    sa_data_skew_line #(
      .DEPTH  (k + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (rd_vld_q),
      .data_i  (bus.rd_data_i[k*DATA_W +: DATA_W]),
      .valid_o (bus.a_valid_o[k]),
      .data_o  (bus.a_data_o[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_sa_data_skew.sv
// Self-checking bench for sa_data_skew (SA_SIZE=4): an event-time model predicts the
// control outputs and a per-lane scoreboard predicts the skewed activations.
module tb_sa_data_skew;
  import sa_data_skew_pkg::*;

  localparam int SA = 4;
  localparam int DW = 8;
  localparam int AW = 10;

  typedef struct {
    int              due;
    logic [DW-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_data_skew_if #(.SA_SIZE(SA), .DATA_W(DW), .ADDR_W(AW)) bus ();

  sa_data_skew #(.SA_SIZE(SA), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t lane_q[SA][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  // Model: mode 0 idle, 1 feeding, 2 waiting for drain/done to finish.
  int   mode = 0;
  int   m_addr = 0;
  int   m_nv = 0;
  int   m_done = -1;
  int   m_idle_at = 0;
  int   pass_id = 0;
  logic pend_vld = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  function automatic logic [DW-1:0] mem_byte(input int p, input int a, input int k);
    return DW'(((p % 7 + 1) << 5) | ((a & 7) << 2) | (k & 3));
  endfunction

  function automatic logic model_idle_now();
    return (mode == 0) || (mode == 2 && cyc >= m_idle_at);
  endfunction

  task automatic push_read(input int a);
    exp_t e;
    for (int k = 0; k < SA; k++) begin
      e.due  = cyc + 2 + k;
      e.data = mem_byte(pass_id, a, k);
      lane_q[k].push_back(e);
    end
  endtask

  // One clock cycle: drive inputs, predict, compare at negedge, advance past posedge.
  task automatic run_cycle(input logic en, input logic rst);
    logic          exp_rd;
    logic          exp_last;
    logic          exp_done;
    logic [AW-1:0] exp_addr;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] got_d;
    rst_n = ~rst;
    bus.data_enable_i = en;
    for (int k = 0; k < SA; k++) begin
      if (pend_vld) bus.rd_data_i[k*DW +: DW] = mem_byte(pass_id, int'(pend_addr), k);
      else          bus.rd_data_i[k*DW +: DW] = DW'($urandom);
    end
    if (mode == 2 && cyc >= m_idle_at) mode = 0;
    exp_rd = 1'b0; exp_last = 1'b0; exp_addr = '0;
    if (mode == 0 && en) begin
      if (bus.num_vec_i != '0) begin
        pass_id++;
        m_nv = int'(bus.num_vec_i);
        exp_rd = 1'b1;
        push_read(0);
        if (m_nv == 1) begin
          exp_last = 1'b1; m_done = cyc + SA + 2; m_idle_at = cyc + SA + 3; mode = 2;
        end else begin
          m_addr = 1; mode = 1;
        end
      end else begin
        m_done = cyc + 1; m_idle_at = cyc + 2; mode = 2;
      end
    end else if (mode == 1 && en) begin
      exp_rd = 1'b1;
      exp_addr = AW'(m_addr);
      push_read(m_addr);
      if (m_addr == m_nv - 1) begin
        exp_last = 1'b1; m_done = cyc + SA + 2; m_idle_at = cyc + SA + 3; mode = 2;
      end else begin
        m_addr++;
      end
    end
    exp_done = (cyc == m_done);
    @(negedge clk);
    checks++;
    if (bus.rd_en_o !== exp_rd) begin
      errors++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, bus.rd_en_o, exp_rd);
    end
    if (exp_rd) begin
      checks++;
      if (bus.rd_addr_o !== exp_addr) begin
        errors++; $display("FAIL rd_addr cyc=%0d got=%0d exp=%0d", cyc, bus.rd_addr_o, exp_addr);
      end
    end
    checks++;
    if (bus.data_last_o !== exp_last) begin
      errors++; $display("FAIL data_last cyc=%0d got=%b exp=%b", cyc, bus.data_last_o, exp_last);
    end
    checks++;
    if (bus.conv_done_o !== exp_done) begin
      errors++; $display("FAIL conv_done cyc=%0d got=%b exp=%b", cyc, bus.conv_done_o, exp_done);
    end
    for (int k = 0; k < SA; k++) begin
      exp_v = 1'b0; exp_d = '0;
      if (lane_q[k].size() > 0 && lane_q[k][0].due == cyc) begin
        exp_v = 1'b1; exp_d = lane_q[k][0].data;
        void'(lane_q[k].pop_front());
      end
      got_d = bus.a_data_o[k*DW +: DW];
      checks++;
      if (bus.a_valid_o[k] !== exp_v || got_d !== exp_d) begin
        errors++;
        $display("FAIL lane%0d cyc=%0d got v=%b d=%h exp v=%b d=%h",
                 k, cyc, bus.a_valid_o[k], got_d, exp_v, exp_d);
      end
    end
    pend_vld  = bus.rd_en_o;
    pend_addr = bus.rd_addr_o;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mode = 0; m_addr = 0; m_done = -1;
      for (int k = 0; k < SA; k++) lane_q[k].delete();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!model_idle_now()) begin
      run_cycle(1'b0, 1'b0);
      n++;
      if (n > 60) begin
        checks++; errors++;
        $display("FAIL wait_idle cycle budget expired at cyc=%0d", cyc);
        break;
      end
    end
    run_cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    run_cycle(1'b0, 1'b0);
    checks++;
    if (bus.rd_addr_o !== '0 || bus.a_valid_o !== '0 || bus.a_data_o !== '0) begin
      errors++;
      $display("FAIL reset_state addr=%0d valid=%b data=%h exp all zero",
               bus.rd_addr_o, bus.a_valid_o, bus.a_data_o);
    end
    run_cycle(1'b0, 1'b0);
  endtask

  task automatic test_basic();
    bus.num_vec_i = AW'(3);
    repeat (3) run_cycle(1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_bubble();
    bus.num_vec_i = AW'(3);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_num_vec_zero();
    bus.num_vec_i = AW'(0);
    run_cycle(1'b1, 1'b0);
    wait_idle();
    run_cycle(1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    bus.num_vec_i = AW'(8);
    repeat (3) run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b1);
    repeat (10) run_cycle(1'b0, 1'b0);
    checks++;
    if (bus.rd_addr_o !== '0) begin
      errors++; $display("FAIL post_reset_addr got=%0d exp=0", bus.rd_addr_o);
    end
    bus.num_vec_i = AW'(2);
    repeat (2) run_cycle(1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bus.num_vec_i = AW'(2);
    repeat (2) run_cycle(1'b1, 1'b0);
    while (!model_idle_now() && n < 60) begin
      run_cycle(1'b0, 1'b0);
      n++;
    end
    bus.num_vec_i = AW'(3);
    repeat (3) run_cycle(1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_enable_held();
    int n = 0;
    bus.num_vec_i = AW'(2);
    run_cycle(1'b1, 1'b0);
    while (!model_idle_now() && n < 60) begin
      run_cycle(1'b1, 1'b0);
      n++;
    end
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.data_enable_i = 1'b0;
    bus.num_vec_i = '0;
    bus.rd_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_bubble();
    test_num_vec_zero();
    test_mid_reset();
    test_back_to_back();
    test_enable_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
